mdr_reg: RTL and testbench
==========================

MDR_REG -- requirements
Module: mdr_reg

Interface
REQ-001 Parameter: WIDTH, default 8, data path width of all buses and the held register.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  capture C_bus into the register this edge.
REQ-005 read  input  1  capture data_in_DRAM into the register this edge (memory read).
REQ-006 write  input  1  present register contents to memory via data_out_DRAM this edge (memory write).
REQ-007 C_bus  input  WIDTH  internal C-bus data source.
REQ-008 data_in_DRAM  input  WIDTH  data returned from DRAM.
REQ-009 data_out_Bbus  output  WIDTH  register contents to B-bus.
REQ-010 data_out_DRAM  output  WIDTH  data to DRAM.

Function
REQ-011 The block SHALL hold one WIDTH-bit register (mdr), reset value 0.
REQ-012 On a rising edge with load=1, mdr SHALL take C_bus.
REQ-013 On a rising edge with load=0 and read=1, mdr SHALL take data_in_DRAM.
REQ-014 load=1 and read=1 together: load SHALL win; data_in_DRAM ignored.
REQ-015 load=0 and read=0: mdr SHALL hold.
REQ-016 data_out_Bbus SHALL equal mdr combinationally; one-cycle latency from load/read edge to visible value.
REQ-017 data_out_DRAM SHALL be a registered output; on a rising edge with write=1 it SHALL take the value of mdr before that edge's update.
REQ-018 write=0: data_out_DRAM SHALL hold its last value.
REQ-019 write with read or load same edge: mdr updates per REQ-012..014; data_out_DRAM gets old mdr, unless REQ-025 applies.
REQ-020 Inputs SHALL be sampled only at rising edges; no combinational path from any input to any output.
REQ-021 Control inputs at X/undriven SHALL be treated as 0 by the bench; design need not resolve X.

Reset
REQ-022 reset=1 at a rising edge SHALL set mdr and data_out_DRAM to 0, overriding load, read and write.
REQ-023 Reset asserted mid-operation SHALL discard any same-edge capture; data_out_Bbus reads 0 the following cycle.
REQ-024 After reset deasserts, the first edge with load/read/write SHALL act normally; no extra latency.

Configuration
REQ-025 Macro MDR_WRITE_FWD_EN: when defined, write=1 and load=1 on the same edge SHALL set data_out_DRAM to C_bus (forwarded new value); when undefined, data_out_DRAM SHALL take old mdr per REQ-019. All other behaviour is identical either way.

Verification
REQ-026 reset=1 one edge, then idle -> data_out_Bbus=0, data_out_DRAM=0.
REQ-027 load=1, C_bus=5 one edge -> data_out_Bbus=5 next cycle; data_out_DRAM unchanged (0).
REQ-028 load=0, read=1, data_in_DRAM=43 -> data_out_Bbus=43; load=1, read=1, C_bus=7, data_in_DRAM=43 -> data_out_Bbus=7.
REQ-029 mdr=43, write=1, C_bus=50, load=0 -> data_out_DRAM=43 after edge, held after write drops; data_out_Bbus stays 43.
REQ-030 mdr=43, write=1, load=1, C_bus=50 -> data_out_Bbus=50; data_out_DRAM=43 without MDR_WRITE_FWD_EN, 50 with it.
REQ-031 mdr=5, reset=1 with load=1, C_bus=9, write=1 -> mdr=0, data_out_DRAM=0.

Source files
------------

// File: rtl/mdr_reg.sv
// Memory data register: one WIDTH-bit register fed from the C-bus or from DRAM, with a registered DRAM write port.
// Optional macro MDR_WRITE_FWD_EN: a same-edge write+load forwards C_bus to data_out_DRAM.
module mdr_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] C_bus,
  input  logic [WIDTH-1:0] data_in_DRAM,
  output logic [WIDTH-1:0] data_out_Bbus,
  output logic [WIDTH-1:0] data_out_DRAM
);

  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] r_dram;
  logic [WIDTH-1:0] w_mdr_next;
  logic [WIDTH-1:0] w_dram_next;

  // Next value of mdr: load has priority over read.
  always_comb begin
    w_mdr_next = r_mdr;
    case ({load, read})
      2'b10, 2'b11: w_mdr_next = C_bus;
      2'b01:        w_mdr_next = data_in_DRAM;
      default:      w_mdr_next = r_mdr;
    endcase
  end

  // Next value of the DRAM port: old mdr on write, unless forwarding a same-edge load.
  always_comb begin
    w_dram_next = r_dram;
    if (write) begin
`ifdef MDR_WRITE_FWD_EN
      if (load) begin
        w_dram_next = C_bus;
      end else begin
        w_dram_next = r_mdr;
      end
`else
      w_dram_next = r_mdr;
`endif
    end else begin
      w_dram_next = r_dram;
    end
  end

  // State update; reset overrides any same-edge capture or write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdr  <= {WIDTH{1'b0}};
      r_dram <= {WIDTH{1'b0}};
    end else begin
      r_mdr  <= w_mdr_next;
      r_dram <= w_dram_next;
    end
  end

  assign data_out_Bbus = r_mdr;
  assign data_out_DRAM = r_dram;

endmodule

// File: tb/tb_mdr_reg.sv
// Self-checking bench for mdr_reg: directed vector table, no-combinational-path check and a random stream against a reference model.
module tb_mdr_reg;

  localparam int WIDTH = 8;
`ifdef MDR_WRITE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic             rst;
    logic             ld;
    logic             rd;
    logic             wr;
    logic [WIDTH-1:0] cbus;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_b;
    logic [WIDTH-1:0] exp_d;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load = 1'b0;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [WIDTH-1:0] C_bus = '0;
  logic [WIDTH-1:0] data_in_DRAM = '0;
  logic [WIDTH-1:0] data_out_Bbus;
  logic [WIDTH-1:0] data_out_DRAM;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  mdr_reg #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .read         (read),
    .write        (write),
    .C_bus        (C_bus),
    .data_in_DRAM (data_in_DRAM),
    .data_out_Bbus(data_out_Bbus),
    .data_out_DRAM(data_out_DRAM)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, pop and compare after the edge.
  task automatic apply(input string name, input logic rst, input logic ld, input logic rd, input logic wr,
                       input logic [WIDTH-1:0] cb, input logic [WIDTH-1:0] di,
                       input logic [WIDTH-1:0] eb, input logic [WIDTH-1:0] ed);
    exp_t e;
    reset = rst; load = ld; read = rd; write = wr; C_bus = cb; data_in_DRAM = di;
    e.b = eb; e.d = ed; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.name, ".bbus"}, data_out_Bbus, e.b);
    check({e.name, ".dram"}, data_out_DRAM, e.d);
  endtask

  vec_t vecs[16];

  initial begin
    logic [WIDTH-1:0] m_mdr;
    logic [WIDTH-1:0] m_dram;
    logic [WIDTH-1:0] held_b;
    logic [WIDTH-1:0] held_d;

    //           rst   ld    rd    wr    cbus     din      exp_b    exp_d
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0,   8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0,   8'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd5,   8'd0,   8'd5,   8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd43,  8'd43,  8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd7,   8'd43,  8'd7,   8'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd43,  8'd43,  8'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd50,  8'd0,   8'd43,  8'd43};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd50,  8'd0,   8'd43,  8'd43};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd50,  8'd0,   8'd50,  FWD ? 8'd50 : 8'd43};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'd50,  FWD ? 8'd50 : 8'd43};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd5,   8'd0,   8'd5,   FWD ? 8'd50 : 8'd43};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd9,   8'd0,   8'd0,   8'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd99,  8'd99,  8'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   8'd0,   8'd99,  8'd99};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd200, 8'd17,  8'd200, FWD ? 8'd200 : 8'd99};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 8'd255, 8'd200, FWD ? 8'd200 : 8'd99};

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ld, vecs[i].rd, vecs[i].wr,
            vecs[i].cbus, vecs[i].din, vecs[i].exp_b, vecs[i].exp_d);
    end

    // Inputs toggling between edges must not reach the outputs.
    held_b = data_out_Bbus;
    held_d = data_out_DRAM;
    load = 1'b1; read = 1'b1; write = 1'b1; reset = 1'b1; C_bus = 8'd17; data_in_DRAM = 8'd34;
    #2;
    check("nocomb.bbus", data_out_Bbus, held_b);
    check("nocomb.dram", data_out_DRAM, held_d);
    load = 1'b0; read = 1'b0; write = 1'b0; reset = 1'b0;
    @(negedge clk);

    // Random stream against a reference model.
    m_mdr  = held_b;
    m_dram = held_d;
    for (int i = 0; i < 60; i++) begin
      logic             r_rst, r_ld, r_rd, r_wr;
      logic [WIDTH-1:0] r_cb, r_di;
      r_rst = ($urandom_range(0, 15) == 0);
      r_ld  = $urandom_range(0, 1);
      r_rd  = $urandom_range(0, 1);
      r_wr  = $urandom_range(0, 1);
      r_cb  = WIDTH'($urandom);
      r_di  = WIDTH'($urandom);
      if (r_rst) begin
        m_mdr  = '0;
        m_dram = '0;
      end else begin
        if (r_wr) m_dram = (FWD && r_ld) ? r_cb : m_mdr;
        if (r_ld) m_mdr = r_cb;
        else if (r_rd) m_mdr = r_di;
      end
      apply($sformatf("rnd%0d", i), r_rst, r_ld, r_rd, r_wr, r_cb, r_di, m_mdr, m_dram);
    end

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
